// File: rtl/masked_and_sched.sv
// masked_and_sched: sequencer for one external 3-share masked AND gadget.
// It holds the gadget inputs stable for the 4-cycle gadget pipeline and injects
// LFSR refresh bits once per operation. One operation is in flight at a time.
module masked_and_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_we,
    input  logic [15:0] seed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_a,
    input  logic [2:0]  in_b,
    output logic [1:0]  g_is0,
    output logic [1:0]  g_is1,
    output logic [1:0]  g_is2,
    output logic [1:0]  g_refreshing,
    input  logic [2:0]  g_os,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_z,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_H1,
        S_H2,
        S_H3,
        S_CAPT,
        S_OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  a_reg;
    logic [2:0]  b_reg;
    logic [15:0] lfsr;
    logic        drive_gadget;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state sequencing through the fixed gadget pipeline.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (in_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_H1;
            S_H1:    state_next = S_H2;
            S_H2:    state_next = S_H3;
            S_H3:    state_next = S_CAPT;
            S_CAPT:  state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture on the input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (state == S_IDLE && in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
        end
    end

    // Refresh LFSR: a seed write overrides the two-step advance made in ISSUE.
    always_ff @(posedge clk) begin
        if (rst)                  lfsr <= 16'hACE1;
        else if (seed_we)         lfsr <= (seed == '0) ? 16'h0001 : seed;
        else if (state == S_ISSUE) lfsr <= lfsr_step(lfsr_step(lfsr));
    end

    // Result capture and registered output-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_z     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == S_CAPT) begin
                out_z     <= g_os;
                out_valid <= 1'b1;
            end else if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Gadget drive and status decode; gadget inputs are zero outside ISSUE..H3.
    always_comb begin
        drive_gadget = (state == S_ISSUE) || (state == S_H1) ||
                       (state == S_H2)    || (state == S_H3);
        in_ready     = (state == S_IDLE);
        busy         = (state != S_IDLE);
        g_is0        = '0;
        g_is1        = '0;
        g_is2        = '0;
        g_refreshing = '0;
        if (drive_gadget) begin
            g_is0 = {b_reg[0], a_reg[0]};
            g_is1 = {b_reg[1], a_reg[1]};
            g_is2 = {b_reg[2], a_reg[2]};
        end
        if (state == S_ISSUE) g_refreshing = lfsr[1:0];
    end

endmodule

// File: doc/masked_and_sched.md
# masked_and_sched

Sequencer for one external 3-share masked AND gadget (`uma2`-style: 2-bit `isN` share pairs, 2-bit `refreshing`, 3-stage registered output). It accepts masked operand pairs over a valid/ready handshake, holds the gadget inputs stable for the full gadget pipeline, injects fresh refresh bits from an internal LFSR exactly once per operation, and returns the result shares over a second valid/ready handshake. Exactly one operation is in flight at any time.

## Interface
- No parameters. Share count is fixed at 3, gadget latency at 4 cycles, LFSR width at 16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `seed_we`  in  1  load `seed` into the LFSR on this edge.
- `seed`  in  16  LFSR seed. The value 0 is replaced by 16'h0001.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in IDLE.
- `in_a`  in  3  shares a0..a2 of operand a (bit i = share i).
- `in_b`  in  3  shares b0..b2 of operand b.
- `g_is0`, `g_is1`, `g_is2`  out  2 each  gadget inputs. Bit 0 = a share, bit 1 = b share.
- `g_refreshing`  out  2  gadget refresh bits.
- `g_os`  in  3  gadget outputs os0..os2.
- `out_valid`  out  1  result shares valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_z`  out  3  result shares z0..z2, where XOR(z) = XOR(a) & XOR(b).
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE → ISSUE → H1 → H2 → H3 → CAPT → OUT → IDLE.
- **IDLE**
  - `in_ready`=1.
  - If `in_valid`, latch `in_a`/`in_b` into operand registers and go to ISSUE.
- **ISSUE, H1, H2, H3**
  - Drive `g_isN` = {b_reg[N], a_reg[N]}.
  - These values are constant across all four cycles, because the gadget samples different cross-products in different stages.
- **ISSUE only**
  - `g_refreshing` = lfsr[1:0].
  - LFSR advances 2 steps at the end of the cycle.
  - In every other state `g_refreshing` = 2'b00.
- **Gadget input hygiene:** in IDLE, CAPT and OUT, `g_isN` = 2'b00. This keeps shares of different operations from ever being combined in the gadget.
- **CAPT:** register `g_os` into `out_z`, then go to OUT.
- **OUT:** `out_valid`=1 and `out_z` is held. On `out_ready`, go to IDLE and clear `out_valid`.
- **LFSR**
  - Fibonacci shift-left step: fb = l[15]^l[13]^l[12]^l[10]; l ← {l[14:0], fb}.
  - Two steps are applied per ISSUE.
- **Seed load**
  - `seed_we` is accepted in any state.
  - It takes priority over the ISSUE advance in the same cycle.
  - The loaded value becomes visible to the next ISSUE.
- **Reset values**
  - state = IDLE, lfsr = 16'hACE1.
  - `out_valid`=0, `out_z`=0, `g_isN`=0, `g_refreshing`=0.
  - `in_ready`=1, `busy`=0.
  - Operand registers = 0.
- **Reset mid-operation:** abort immediately with reset values. The gadget pipeline contents are discarded and never captured.
- **Drop on reset edge:** `in_valid` and `out_ready` are ignored on the edge where `rst`=1.

## Timing
- Accept on edge T, so the FSM enters ISSUE in cycle T+1.
- Gadget inputs are driven in cycles T+1..T+4.
- Refresh bits are present only in T+1.
- `g_os` is valid in cycle T+5 (CAPT) and captured at the end of T+5.
- `out_valid` first goes high in cycle T+6.
- Accept-to-`out_valid` latency is 6 cycles.
- Maximum throughput is one operation per 7 cycles, when `out_ready` is held high.
- `in_ready` has no combinational path from `out_ready`. A new operation is accepted no earlier than the cycle after the OUT handshake.
- `out_valid` and `out_z` are registered. Once `out_valid` rises, `out_z` is stable until the handshake completes.

## Test plan
- **Reset, then one operation.**
  - Stimulus: `in_a`=3'b001, `in_b`=3'b111 accepted at T.
  - Required: `g_refreshing`=2'b01 (ACE1[1:0]) in T+1 and 00 elsewhere.
  - Required: `g_is0`=2'b11, `g_is1`=2'b10, `g_is2`=2'b10 for T+1..T+4.
  - Required: `out_valid` at T+6 with XOR(`out_z`)=1.
- **Exhaustive shares.**
  - Stimulus: all 64 (`in_a`,`in_b`) combinations back-to-back with `out_ready`=1.
  - Required: XOR(`out_z`) = XOR(`in_a`) & XOR(`in_b`) every time.
  - Required: one operation per 7 cycles.
  - Required: `g_isN`=0 in every IDLE/CAPT/OUT cycle.
- **Backpressure.**
  - Stimulus: `out_ready`=0 for 10 cycles after `out_valid`.
  - Required: `out_z` stable, `in_ready`=0, `busy`=1.
  - Required: on `out_ready`=1, IDLE next cycle.
- **Seed handling.**
  - Stimulus: `seed_we` with `seed`=0, then one operation.
  - Required: lfsr = 0001, so `g_refreshing`=2'b01.
  - Stimulus: `seed_we` coinciding with ISSUE.
  - Required: the seed value wins, with no 2-step advance.
- **Reset in H2.**
  - Stimulus: assert `rst` during H2.
  - Required: all outputs at reset values next cycle, and no `out_valid` for that operation.
  - Required: the next accepted operation gives a correct result and uses refresh bits from 16'hACE1.
